// File: rtl/gpio_in_pkg.sv
// Shared constants and per-pin state type for the GPIO input conditioner.
package gpio_in_pkg;

  localparam int unsigned FILT_W          = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned PRESC_W         = 16;

  typedef struct packed {
    logic [FILT_W-1:0] cnt;
    logic              level;
    logic              prev;
  } pin_state_t;

endpackage

// File: rtl/gpio_in_pin_filter.sv
// One GPIO input: synchroniser, glitch filter, edge detect and sticky edge flag.
module gpio_in_pin_filter
  import gpio_in_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              pad_i,
  input  logic              filt_en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              tick_i,
  input  logic              rise_ie_i,
  input  logic              fall_ie_i,
  input  logic              flag_clr_i,
  output logic              level_o,
  output logic              rise_o,
  output logic              fall_o,
  output logic              flag_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  pin_state_t             st_q, st_d;
  logic                   flag_q, flag_d;
  logic                   s;
  logic                   rise, fall;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q <= '0;
      st_q   <= '0;
      flag_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      st_q   <= st_d;
      flag_q <= flag_d;
    end
  end

  // Filter: a mismatch must survive cnt>=L on a tick before the level flips.
  always_comb begin
    st_d      = st_q;
    st_d.prev = st_q.level;
    if (!filt_en_i) begin
      st_d.level = s;
      st_d.cnt   = '0;
    end else if (s == st_q.level) begin
      st_d.cnt = '0;
    end else if (tick_i) begin
      if (st_q.cnt >= filt_len_i) begin
        st_d.level = ~st_q.level;
        st_d.cnt   = '0;
      end else begin
        st_d.cnt = st_q.cnt + FILT_W'(1);
      end
    end
  end

  assign rise   = st_q.level & ~st_q.prev;
  assign fall   = ~st_q.level & st_q.prev;
  assign flag_d = (flag_q & ~flag_clr_i) | (rise & rise_ie_i) | (fall & fall_ie_i);

  assign level_o = st_q.level;
  assign rise_o  = rise;
  assign fall_o  = fall;
  assign flag_o  = flag_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner top: per-pin filters, shared filter tick and combined irq.
// Optional GPIO_IN_PRESCALE_EN adds a 16-bit divider that slows the filter tick.
module gpio_in_conditioner
  import gpio_in_pkg::*;
#(
  parameter int unsigned NPINS       = 14,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [NPINS-1:0]  pad_in,
  input  logic [NPINS-1:0]  filt_en,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [NPINS-1:0]  rise_ie,
  input  logic [NPINS-1:0]  fall_ie,
  input  logic [NPINS-1:0]  flag_clr,
  input  logic [3:0]        prescale,
  output logic [NPINS-1:0]  gpio_out,
  output logic [NPINS-1:0]  rise_o,
  output logic [NPINS-1:0]  fall_o,
  output logic [NPINS-1:0]  edge_flag,
  output logic              irq_o
);

  logic tick;
  logic irq_q;

`ifdef GPIO_IN_PRESCALE_EN
  logic [PRESC_W-1:0] div_q;
  logic [PRESC_W-1:0] div_mask;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) div_q <= '0;
    else          div_q <= div_q + PRESC_W'(1);
  end

  // Tick whenever the low 'prescale' bits of the free-running divider are zero.
  assign div_mask = PRESC_W'((32'd1 << prescale) - 32'd1);
  assign tick     = (div_q & div_mask) == '0;
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign tick            = 1'b1;
`endif

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    gpio_in_pin_filter #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_pin (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .pad_i      (pad_in[i]),
      .filt_en_i  (filt_en[i]),
      .filt_len_i (filt_len),
      .tick_i     (tick),
      .rise_ie_i  (rise_ie[i]),
      .fall_ie_i  (fall_ie[i]),
      .flag_clr_i (flag_clr[i]),
      .level_o    (gpio_out[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i]),
      .flag_o     (edge_flag[i])
    );
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) irq_q <= 1'b0;
    else          irq_q <= |edge_flag;
  end

  assign irq_o = irq_q;

endmodule
